// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
// Main control unit for a multicycle MIPS-style datapath. A registered Moore
// FSM walks each instruction through fetch, decode and the per-class execute,
// memory and write-back steps, and drives the datapath strobes and selects.
//
// Ports
//   Clk          in   rising-edge system clock
//   Reset        in   asynchronous active-high reset
//   Op[5:0]      in   opcode field IR[31:26]; sampled only in DECODE
//   MemReady     in   memory access completes in the cycle it is high
//   PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
//   ALUSrcA, RegWrite, RegDst          out  datapath controls
//   PCSource[1:0], ALUOp[1:0], ALUSrcB[1:0]  out  mux / ALU selects
//   IllegalOp    out  high for the DECODE cycle of an unsupported opcode
//   State[3:0]   out  current FSM state (debug / verification)
// -----------------------------------------------------------------------------
module multicycle_control (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [5:0] Op,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       MemtoReg,
    output logic       IRWrite,
    output logic       ALUSrcA,
    output logic       RegWrite,
    output logic       RegDst,
    output logic [1:0] PCSource,
    output logic [1:0] ALUOp,
    output logic [1:0] ALUSrcB,
    output logic       IllegalOp,
    output logic [3:0] State
);

    localparam logic [3:0] ST_FETCH  = 4'd0;
    localparam logic [3:0] ST_DECODE = 4'd1;
    localparam logic [3:0] ST_MEMADR = 4'd2;
    localparam logic [3:0] ST_MEMRD  = 4'd3;
    localparam logic [3:0] ST_MEMWB  = 4'd4;
    localparam logic [3:0] ST_MEMWR  = 4'd5;
    localparam logic [3:0] ST_EXEC   = 4'd6;
    localparam logic [3:0] ST_RCOMP  = 4'd7;
    localparam logic [3:0] ST_BRANCH = 4'd8;
    localparam logic [3:0] ST_JUMP   = 4'd9;
    localparam logic [3:0] ST_ADDIEX = 4'd10;
    localparam logic [3:0] ST_ADDIWB = 4'd11;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    logic [3:0] state_r;
    logic [3:0] next_state_s;
    // Remembers whether the decoded memory instruction was a store, so MEMADR
    // can branch without looking at Op again (Op may have moved on by then).
    logic       is_store_r;

    // True for every opcode this controller implements.
    function automatic logic op_legal(input logic [5:0] op);
        logic legal;
        case (op)
            OP_RTYPE, OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW: legal = 1'b1;
            default:                                        legal = 1'b0;
        endcase
        return legal;
    endfunction

    assign State = state_r;

    // State register with asynchronous reset to FETCH.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_r <= ST_FETCH;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Load/store flag, captured only while decoding.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            is_store_r <= 1'b0;
        end else if (state_r == ST_DECODE) begin
            is_store_r <= (Op == OP_SW);
        end else begin
            is_store_r <= is_store_r;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state_s = ST_FETCH;
        case (state_r)
            ST_FETCH: begin
                if (MemReady) begin
                    next_state_s = ST_DECODE;
                end else begin
                    next_state_s = ST_FETCH;
                end
            end
            ST_DECODE: begin
                case (Op)
                    OP_LW, OP_SW: next_state_s = ST_MEMADR;
                    OP_RTYPE:     next_state_s = ST_EXEC;
                    OP_BEQ:       next_state_s = ST_BRANCH;
                    OP_J:         next_state_s = ST_JUMP;
                    OP_ADDI:      next_state_s = ST_ADDIEX;
                    default:      next_state_s = ST_FETCH;
                endcase
            end
            ST_MEMADR: begin
                if (is_store_r) begin
                    next_state_s = ST_MEMWR;
                end else begin
                    next_state_s = ST_MEMRD;
                end
            end
            ST_MEMRD: begin
                if (MemReady) begin
                    next_state_s = ST_MEMWB;
                end else begin
                    next_state_s = ST_MEMRD;
                end
            end
            ST_MEMWR: begin
                if (MemReady) begin
                    next_state_s = ST_FETCH;
                end else begin
                    next_state_s = ST_MEMWR;
                end
            end
            ST_EXEC:   next_state_s = ST_RCOMP;
            ST_ADDIEX: next_state_s = ST_ADDIWB;
            ST_MEMWB, ST_RCOMP, ST_BRANCH, ST_JUMP, ST_ADDIWB:
                       next_state_s = ST_FETCH;
            default:   next_state_s = ST_FETCH;
        endcase
    end

    // Moore outputs decoded from the state; Reset forces every output low so
    // an abandoned instruction cannot issue any further strobe.
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        MemtoReg    = 1'b0;
        IRWrite     = 1'b0;
        ALUSrcA     = 1'b0;
        RegWrite    = 1'b0;
        RegDst      = 1'b0;
        PCSource    = 2'b00;
        ALUOp       = 2'b00;
        ALUSrcB     = 2'b00;
        IllegalOp   = 1'b0;
        if (Reset) begin
            // All outputs hold their zero defaults.
        end else begin
            case (state_r)
                ST_FETCH: begin
                    MemRead = 1'b1;
                    ALUSrcB = 2'b01;
                    IRWrite = MemReady;
                    PCWrite = MemReady;
                end
                ST_DECODE: begin
                    ALUSrcB   = 2'b11;
                    IllegalOp = ~op_legal(Op);
                end
                ST_MEMADR: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                end
                ST_MEMRD: begin
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                end
                ST_MEMWB: begin
                    MemtoReg = 1'b1;
                    RegWrite = 1'b1;
                end
                ST_MEMWR: begin
                    MemWrite = 1'b1;
                    IorD     = 1'b1;
                end
                ST_EXEC: begin
                    ALUSrcA = 1'b1;
                    ALUOp   = 2'b10;
                end
                ST_RCOMP: begin
                    RegDst   = 1'b1;
                    RegWrite = 1'b1;
                end
                ST_BRANCH: begin
                    ALUSrcA     = 1'b1;
                    ALUOp       = 2'b01;
                    PCWriteCond = 1'b1;
                    PCSource    = 2'b01;
                end
                ST_JUMP: begin
                    PCWrite  = 1'b1;
                    PCSource = 2'b10;
                end
                ST_ADDIEX: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                end
                ST_ADDIWB: begin
                    RegWrite = 1'b1;
                end
                default: begin
                    // Unused encodings drive nothing.
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// -----------------------------------------------------------------------------
// tb_multicycle_control
// Randomized and directed bench for multicycle_control. A reference model
// tracks the expected state as "current step plus remaining steps of the
// instruction path" and derives the expected outputs per step; directed
// sequences pin the model with hand-written state/strobe traces.
// -----------------------------------------------------------------------------
module tb_multicycle_control;

    logic       Clk;
    logic       Reset;
    logic [5:0] Op;
    logic       MemReady;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg;
    logic       IRWrite, ALUSrcA, RegWrite, RegDst, IllegalOp;
    logic [1:0] PCSource, ALUOp, ALUSrcB;
    logic [3:0] State;

    multicycle_control dut (
        .Clk(Clk), .Reset(Reset), .Op(Op), .MemReady(MemReady),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
        .IRWrite(IRWrite), .ALUSrcA(ALUSrcA), .RegWrite(RegWrite),
        .RegDst(RegDst), .PCSource(PCSource), .ALUOp(ALUOp),
        .ALUSrcB(ALUSrcB), .IllegalOp(IllegalOp), .State(State)
    );

    logic [16:0] dut_vec;
    assign dut_vec = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg,
                      IRWrite, ALUSrcA, RegWrite, RegDst, PCSource, ALUOp,
                      ALUSrcB, IllegalOp};

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int total = 0;
    int bad   = 0;

    // Model: the step the instruction is on, plus the steps still ahead.
    int exp_state = 0;
    int rest[$];

    // Traces recorded by each step, for the directed literal checks.
    int seen_st[$];
    int seen_rw[$];
    int seen_mw[$];
    int seen_irw[$];
    int seen_ill[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit legal_op(input logic [5:0] op);
        return op == 6'b100011 || op == 6'b101011 || op == 6'b000000 ||
               op == 6'b000100 || op == 6'b000010 || op == 6'b001000;
    endfunction

    // Expected output vector for a given step of an instruction.
    function automatic logic [16:0] exp_vec(input int s, input logic mr, input logic [5:0] op);
        logic pcw, pcwc, iord, mrd, mwr, m2r, irw, asa, rw, rd, ill;
        logic [1:0] pcs, aop, asb;
        {pcw, pcwc, iord, mrd, mwr, m2r, irw, asa, rw, rd, ill} = 11'b0;
        pcs = 2'b00; aop = 2'b00; asb = 2'b00;
        if (s == 0)  begin mrd = 1'b1; asb = 2'b01; irw = mr; pcw = mr; end
        if (s == 1)  begin asb = 2'b11; ill = !legal_op(op); end
        if (s == 2 || s == 10) begin asa = 1'b1; asb = 2'b10; end
        if (s == 3)  begin mrd = 1'b1; iord = 1'b1; end
        if (s == 4)  begin m2r = 1'b1; rw = 1'b1; end
        if (s == 5)  begin mwr = 1'b1; iord = 1'b1; end
        if (s == 6)  begin asa = 1'b1; aop = 2'b10; end
        if (s == 7)  begin rd = 1'b1; rw = 1'b1; end
        if (s == 8)  begin asa = 1'b1; aop = 2'b01; pcwc = 1'b1; pcs = 2'b01; end
        if (s == 9)  begin pcw = 1'b1; pcs = 2'b10; end
        if (s == 11) begin rw = 1'b1; end
        return {pcw, pcwc, iord, mrd, mwr, m2r, irw, asa, rw, rd, pcs, aop, asb, ill};
    endfunction

    // Advance the model by one clock using this cycle's inputs.
    task automatic model_advance(input logic mr, input logic [5:0] op);
        bit waiting;
        waiting = (exp_state == 0 || exp_state == 3 || exp_state == 5) && !mr;
        if (!waiting) begin
            if (exp_state == 1) begin
                rest.delete();
                case (op)
                    6'b100011: rest = '{2, 3, 4};
                    6'b101011: rest = '{2, 5};
                    6'b000000: rest = '{6, 7};
                    6'b000100: rest = '{8};
                    6'b000010: rest = '{9};
                    6'b001000: rest = '{10, 11};
                    default:   rest.delete();
                endcase
            end
            if (rest.size() > 0) exp_state = rest.pop_front();
            else if (exp_state == 0) exp_state = 1;
            else exp_state = 0;
        end
    endtask

    // One cycle: drive inputs just after the falling edge, check, advance.
    task automatic step(input logic mr, input logic [5:0] op);
        MemReady = mr;
        Op       = op;
        #1;
        chk("state", {28'd0, State}, exp_state);
        chk("outputs", {15'd0, dut_vec}, {15'd0, exp_vec(exp_state, mr, op)});
        seen_st.push_back(int'(State));
        seen_rw.push_back(int'(RegWrite));
        seen_mw.push_back(int'(MemWrite));
        seen_irw.push_back(int'(IRWrite));
        seen_ill.push_back(int'(IllegalOp));
        model_advance(mr, op);
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        #1;
        chk("rst_state", {28'd0, State}, 32'd0);
        chk("rst_outputs", {15'd0, dut_vec}, 32'd0);
        @(posedge Clk);
        @(negedge Clk);
        chk("rst_hold_outputs", {15'd0, dut_vec}, 32'd0);
        Reset = 1'b0;
        exp_state = 0;
        rest.delete();
    endtask

    task automatic clear_seen();
        seen_st.delete(); seen_rw.delete(); seen_mw.delete();
        seen_irw.delete(); seen_ill.delete();
    endtask

    task automatic chk_trace(input string name, input int act[$], input int exp[$]);
        chk({name, "_len"}, act.size(), exp.size());
        for (int i = 0; i < exp.size() && i < act.size(); i++)
            chk(name, act[i], exp[i]);
    endtask

    // Reset, then run n steps with a fixed opcode and a per-step MemReady mask.
    task automatic run_seq(input int n, input logic [5:0] op, input logic [15:0] mr_bits);
        do_reset();
        clear_seen();
        for (int i = 0; i < n; i++) step(mr_bits[i], op);
    endtask

    logic [5:0] ops[6] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000010, 6'b001000};

    initial begin
        Reset = 1'b1;
        MemReady = 1'b0;
        Op = 6'd0;

        // lw, memory always ready.
        run_seq(6, 6'b100011, 16'hFFFF);
        chk_trace("lw_states", seen_st, '{0, 1, 2, 3, 4, 0});
        chk_trace("lw_regwrite", seen_rw, '{0, 0, 0, 0, 1, 0});

        // sw with two wait cycles in MEMWR.
        run_seq(7, 6'b101011, 16'b1110_0111);
        chk_trace("sw_states", seen_st, '{0, 1, 2, 5, 5, 5, 0});
        chk_trace("sw_memwrite", seen_mw, '{0, 0, 0, 1, 1, 1, 0});

        // FETCH stalled three cycles.
        run_seq(5, 6'b000000, 16'b1_1000);
        chk_trace("fetch_states", seen_st, '{0, 0, 0, 0, 1});
        chk_trace("fetch_irwrite", seen_irw, '{0, 0, 0, 1, 0});

        run_seq(4, 6'b000100, 16'hFFFF);
        chk_trace("beq_states", seen_st, '{0, 1, 8, 0});
        run_seq(4, 6'b000010, 16'hFFFF);
        chk_trace("j_states", seen_st, '{0, 1, 9, 0});
        run_seq(3, 6'b111111, 16'hFFFF);
        chk_trace("illegal_states", seen_st, '{0, 1, 0});
        chk_trace("illegal_pulse", seen_ill, '{0, 1, 0});
        run_seq(5, 6'b000000, 16'hFFFF);
        chk_trace("rtype_states", seen_st, '{0, 1, 6, 7, 0});
        run_seq(5, 6'b001000, 16'hFFFF);
        chk_trace("addi_states", seen_st, '{0, 1, 10, 11, 0});

        // Reset in the middle of a MEMRD cycle.
        run_seq(4, 6'b100011, 16'b0111);
        chk("memrd_before_reset", {28'd0, State}, 32'd3);
        #2;
        Reset = 1'b1;
        #1;
        chk("memrd_reset_state", {28'd0, State}, 32'd0);
        chk("memrd_reset_memread", {31'd0, MemRead}, 32'd0);
        chk("memrd_reset_outputs", {15'd0, dut_vec}, 32'd0);
        @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
        exp_state = 0;
        rest.delete();
        clear_seen();
        step(1'b1, 6'b000100);
        step(1'b1, 6'b000100);
        chk_trace("after_reset_states", seen_st, '{0, 1});

        // Randomized run against the model, with occasional resets.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            logic [5:0] op;
            logic       mr;
            if ($urandom_range(0, 199) == 0) do_reset();
            mr = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 4) == 0) op = 6'($urandom_range(0, 63));
            else op = ops[$urandom_range(0, 5)];
            step(mr, op);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
